// File: rtl/wb_queue_if.sv
// Bus bundle for wb_queue: producer handshake, register-file write port,
// and the two forwarding lookup ports.
interface wb_queue_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_reg;
  logic [31:0]   in_data;
  logic          wb_stall;
  logic          RegWrite;
  logic [4:0]    write_reg;
  logic [31:0]   write_data;
  logic [4:0]    fwd_reg_1;
  logic [4:0]    fwd_reg_2;
  logic          fwd_hit_1;
  logic          fwd_hit_2;
  logic [31:0]   fwd_data_1;
  logic [31:0]   fwd_data_2;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_reg, in_data, wb_stall, fwd_reg_1, fwd_reg_2,
    input  in_ready, RegWrite, write_reg, write_data,
           fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, wb_stall, fwd_reg_1, fwd_reg_2,
    output in_ready, RegWrite, write_reg, write_data,
           fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2, count
  );
endinterface

// File: rtl/wb_queue.sv
// In-order write-back queue: buffers register writes, drains one per
// unstalled cycle, and forwards the youngest pending value per lookup.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input logic     clk,
  input logic     rst_n,
  wb_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [4:0]    reg_mem_r  [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          in_ready_s;
  logic          push_s;
  logic          pop_s;
  logic [4:0]    write_reg_s;
  logic [31:0]   write_data_s;
  logic [32:0]   fwd_1_s;
  logic [32:0]   fwd_2_s;

  // Scan from oldest to youngest so the last match wins; entries beyond
  // count are stale storage and must never hit.
  function automatic logic [32:0] lookup(
    input logic [4:0]    key,
    input logic [AW-1:0] head,
    input logic [CW-1:0] cnt,
    input logic [4:0]    regs  [DEPTH],
    input logic [31:0]   datas [DEPTH]
  );
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = {1'b0, 32'd0};
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + AW'(k);
      if ((CW'(k) < cnt) && (key != 5'd0) && (regs[idx] == key)) begin
        res = {1'b1, datas[idx]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Handshake and drain qualifiers
  always_comb begin
    in_ready_s = (count_r < FULL_C);
    push_s     = bus.in_valid && in_ready_s && (bus.in_reg != 5'd0);
    pop_s      = (count_r != {CW{1'b0}}) && !bus.wb_stall;
  end

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + AW'(1'b1);
      end
      if (pop_s) begin
        head_r <= head_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; validity is tracked by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      reg_mem_r[tail_r]  <= bus.in_reg;
      data_mem_r[tail_r] <= bus.in_data;
    end
  end

  // Head entry presented to the register file
  always_comb begin
    if (count_r != {CW{1'b0}}) begin
      write_reg_s  = reg_mem_r[head_r];
      write_data_s = data_mem_r[head_r];
    end else begin
      write_reg_s  = 5'd0;
      write_data_s = 32'd0;
    end
  end

  // Forwarding lookups see only queued entries, never the live offer
  always_comb begin
    fwd_1_s = lookup(bus.fwd_reg_1, head_r, count_r, reg_mem_r, data_mem_r);
    fwd_2_s = lookup(bus.fwd_reg_2, head_r, count_r, reg_mem_r, data_mem_r);
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.RegWrite   = pop_s;
  assign bus.write_reg  = write_reg_s;
  assign bus.write_data = write_data_s;
  assign bus.fwd_hit_1  = fwd_1_s[32];
  assign bus.fwd_data_1 = fwd_1_s[31:0];
  assign bus.fwd_hit_2  = fwd_2_s[32];
  assign bus.fwd_data_2 = fwd_2_s[31:0];
  assign bus.count      = count_r;
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a vector table for single-cycle behaviour
// plus sequences for stall/drain, pointer wrap and mid-operation reset.
module tb_wb_queue;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  wb_queue_if #(.DEPTH(DEPTH)) bus ();

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        v;
    logic [4:0]  r;
    logic [31:0] d;
    logic        st;
    logic [4:0]  f1;
    logic [4:0]  f2;
    logic        e_rdy;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
    logic [2:0]  e_cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  vec_t vecs [17];
  ent_t model_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                       input logic st, input logic [4:0] f1, input logic [4:0] f2);
    bus.in_valid  = v;
    bus.in_reg    = r;
    bus.in_data   = d;
    bus.wb_stall  = st;
    bus.fwd_reg_1 = f1;
    bus.fwd_reg_2 = f2;
  endtask

  initial begin
    int   offer_idx;
    int   accepted;
    int   dut_writes;
    logic exp_rdy;
    logic exp_rw;
    ent_t e;

    total  = 0;
    passed = 0;

    //            v     r      d              st    f1     f2    rdy   rw    wr     wd             h1    d1             h2    d2             cnt
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[1]  = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 32'h12345678, 3'd1};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[6]  = '{1'b1, 5'd7, 32'hA,        1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[7]  = '{1'b1, 5'd7, 32'hB,        1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 32'hA,        1'b1, 32'hA,        1'b0, 32'h0,        3'd1};
    vecs[8]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 32'hA,        1'b1, 32'hB,        1'b0, 32'h0,        3'd2};
    vecs[9]  = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 32'hA,        1'b1, 32'hB,        1'b1, 32'h33,       3'd3};
    vecs[10] = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd9, 5'd1, 1'b0, 1'b0, 5'd7, 32'hA,        1'b1, 32'h99,       1'b0, 32'h0,        3'd4};
    vecs[11] = '{1'b1, 5'd1, 32'h11,       1'b0, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 32'hA,        1'b1, 32'hB,        1'b1, 32'h33,       3'd4};
    vecs[12] = '{1'b1, 5'd1, 32'h11,       1'b0, 5'd7, 5'd1, 1'b1, 1'b1, 5'd7, 32'hB,        1'b1, 32'hB,        1'b0, 32'h0,        3'd3};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd1, 1'b1, 1'b1, 5'd3, 32'h33,       1'b0, 32'h0,        1'b1, 32'h11,       3'd3};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 32'h99,       1'b0, 32'h0,        1'b1, 32'h99,       3'd2};
    vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd1, 5'd0, 1'b1, 1'b1, 5'd1, 32'h11,       1'b1, 32'h11,       1'b0, 32'h0,        3'd1};
    vecs[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        3'd0};

    // Reset state, with a live offer and lookups that must be ignored
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'h5555, 1'b0, 5'd5, 5'd5);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("rst write_reg", 32'(bus.write_reg), 32'd0);
    chk("rst write_data", bus.write_data, 32'd0);
    chk("rst fwd_hit_1", 32'(bus.fwd_hit_1), 32'd0);
    chk("rst fwd_data_2", bus.fwd_data_2, 32'd0);
    chk("rst count", 32'(bus.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].st, vecs[i].f1, vecs[i].f2);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d RegWrite", i), 32'(bus.RegWrite), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d write_reg", i), 32'(bus.write_reg), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d write_data", i), bus.write_data, vecs[i].e_wd);
      chk($sformatf("v%0d fwd1", i), (bus.fwd_hit_1 ? 32'h1 : 32'h0) ^ bus.fwd_data_1, (vecs[i].e_h1 ? 32'h1 : 32'h0) ^ vecs[i].e_d1);
      chk($sformatf("v%0d fwd_hit_2", i), 32'(bus.fwd_hit_2), 32'(vecs[i].e_h2));
      chk($sformatf("v%0d fwd_data_2", i), bus.fwd_data_2, vecs[i].e_d2);
      chk($sformatf("v%0d count", i), 32'(bus.count), 32'(vecs[i].e_cnt));
    end

    // Fill under stall, refuse a 5th offer, then drain 1..4 back to back
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'd0, 5'd0);
    end
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h555, 1'b1, 5'd0, 5'd0);
    #1;
    chk("full count", 32'(bus.count), 32'd4);
    chk("full in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    for (int j = 1; j <= 4; j++) begin
      #1;
      chk($sformatf("drain%0d RegWrite", j), 32'(bus.RegWrite), 32'd1);
      chk($sformatf("drain%0d write_reg", j), 32'(bus.write_reg), 32'(j));
      chk($sformatf("drain%0d write_data", j), bus.write_data, 32'h100 + 32'(j));
      @(negedge clk);
    end
    #1;
    chk("drained count", 32'(bus.count), 32'd0);
    chk("drained RegWrite", 32'(bus.RegWrite), 32'd0);

    // Pointer wrap: fill, then offer continuously with stall low
    model_q.delete();
    accepted   = 0;
    dut_writes = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(10 + i), 32'hC0DE0000 + 32'(i), 1'b1, 5'd0, 5'd0);
      e.r = 5'(10 + i);
      e.d = 32'hC0DE0000 + 32'(i);
      model_q.push_back(e);
      accepted++;
    end
    offer_idx = DEPTH;
    for (int c = 0; c < 3 * DEPTH + 10; c++) begin
      @(negedge clk);
      if (c < 3 * DEPTH) begin
        drive(1'b1, 5'(10 + offer_idx), 32'hC0DE0000 + 32'(offer_idx), 1'b0, 5'd0, 5'd0);
      end else begin
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
      end
      #1;
      exp_rdy = (model_q.size() < DEPTH);
      exp_rw  = (model_q.size() != 0);
      chk($sformatf("wrap c%0d in_ready", c), 32'(bus.in_ready), 32'(exp_rdy));
      chk($sformatf("wrap c%0d RegWrite", c), 32'(bus.RegWrite), 32'(exp_rw));
      if (bus.RegWrite) begin
        dut_writes++;
      end
      if (exp_rw) begin
        chk($sformatf("wrap c%0d write_reg", c), 32'(bus.write_reg), 32'(model_q[0].r));
        chk($sformatf("wrap c%0d write_data", c), bus.write_data, model_q[0].d);
        void'(model_q.pop_front());
      end
      if (exp_rdy && bus.in_valid) begin
        e.r = bus.in_reg;
        e.d = bus.in_data;
        model_q.push_back(e);
        accepted++;
        offer_idx++;
      end
    end
    chk("wrap writes vs accepted", 32'(dut_writes), 32'(accepted));
    chk("wrap final count", 32'(bus.count), 32'(model_q.size()));

    // Mid-cycle reset with three pending entries
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(20 + i), 32'hDEAD0000 + 32'(i), 1'b1, 5'd0, 5'd0);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd22);
    #1;
    chk("pre-rst RegWrite", 32'(bus.RegWrite), 32'd1);
    chk("pre-rst count", 32'(bus.count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("mid-rst count", 32'(bus.count), 32'd0);
    chk("mid-rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid-rst fwd_hit_2", 32'(bus.fwd_hit_2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd0);
    #1;
    chk("post-rst first count", 32'(bus.count), 32'd1);
    chk("post-rst first write_reg", 32'(bus.write_reg), 32'd6);
    chk("post-rst first write_data", bus.write_data, 32'h66);
    chk("post-rst stale fwd", 32'(bus.fwd_hit_1), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-rst idle%0d RegWrite", c), 32'(bus.RegWrite), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
